mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, the number of cycles the memory address is held before read data is valid (legal range 1..4).
REQ-002 Port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port if_req  input  1  instruction-fetch request, held high until if_done.
REQ-005 Port if_addr  input  32  fetch address (the PC).
REQ-006 Port if_done  output  1  one-cycle pulse when fetch data is valid on if_rdata.
REQ-007 Port if_rdata  output  32  registered fetch data, destined for the instruction register.
REQ-008 Port d_req  input  1  data-access request, held high until d_done.
REQ-009 Port d_we  input  1  1 = store, 0 = load; sampled at grant.
REQ-010 Port d_addr  input  32  data address (the ALU-output register).
REQ-011 Port d_wdata  input  32  store data (the B register).
REQ-012 Port d_done  output  1  one-cycle pulse marking load data valid or store complete.
REQ-013 Port d_rdata  output  32  registered load data, destined for the MDR.
REQ-014 Port mem_addr  output  32  memory address.
REQ-015 Port mem_wr  output  1  memory write strobe.
REQ-016 Port mem_wdata  output  32  memory write data.
REQ-017 Port mem_rdata  input  32  memory read data.
REQ-018 Port busy  output  1  high in every state other than IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT_RD, GRANT_WR and RESP.
REQ-020 Requests SHALL be sampled only in IDLE; while no request is pending the FSM SHALL stay in IDLE.
REQ-021 When only one of the two requests is high in IDLE, that port SHALL be granted.
REQ-022 When if_req and d_req are both high in IDLE, the data port SHALL win, unless the previous grant was also data, in which case fetch SHALL win.
REQ-023 At grant the arbiter SHALL latch the port, the address, d_we and d_wdata; mem_addr and mem_wdata SHALL be driven from these latches only.
REQ-024 A load or a fetch SHALL move to GRANT_RD, where the wait counter loads MEM_LAT-1 and decrements each cycle.
REQ-025 In GRANT_RD, mem_addr SHALL be held for MEM_LAT cycles; on the last cycle, mem_rdata SHALL be captured into if_rdata or d_rdata, and the FSM SHALL move to RESP.
REQ-026 A store SHALL move to GRANT_WR, where mem_wr is high for exactly one cycle; the FSM SHALL then move to RESP.
REQ-027 In RESP, exactly one of if_done or d_done SHALL be high for one cycle (the granted port); the FSM SHALL then return to IDLE.
REQ-028 Read latency: a request seen in IDLE at cycle N SHALL produce done at cycle N+MEM_LAT+1.
REQ-029 Write latency: a request seen in IDLE at cycle N SHALL produce mem_wr at N+1 and d_done at N+2.
REQ-030 Each rdata register SHALL hold its value until the next read on that same port.
REQ-031 Requesters SHALL deassert req in the cycle after done unless they are issuing a new access; back-to-back accesses SHALL therefore be spaced by at least one IDLE cycle.
REQ-032 A request dropped before done SHALL NOT abort the access; the access completes and done still pulses.
REQ-033 mem_wr SHALL be 0 in every state except GRANT_WR.
REQ-034 The unselected port's done SHALL stay 0, and its rdata SHALL stay unchanged.

Reset
REQ-035 Reset SHALL immediately force IDLE, including when asserted mid-access; no done pulse SHALL follow.
REQ-036 On reset, all outputs (both rdata registers, mem_addr, mem_wdata, mem_wr, both done signals and busy) SHALL be 0, the wait counter SHALL be 0, and the last-grant flag SHALL be fetch.

Structure
REQ-037 The state enum, the MEM_LAT default and the counter width (3 bits) SHALL live in the shared package mem_arb_pkg.
REQ-038 The block SHALL be a single module with no sub-module; the wait counter SHALL be inline.

Verification
REQ-039 With MEM_LAT=2, raise if_req, if_addr=0x10 and mem_rdata=0xDEADBEEF at cycle 0 -> mem_addr=0x10 in cycles 1-2, if_done at cycle 3, if_rdata=0xDEADBEEF.
REQ-040 Raise d_req, d_we=1, d_addr=0x40, d_wdata=0x1234 at cycle 0 -> mem_wr=1 only in cycle 1 with mem_addr=0x40 and mem_wdata=0x1234; d_done at cycle 2.
REQ-041 Hold if_req and d_req both high, each requester re-requesting after its done -> grant order data, fetch, data, fetch; no port is granted twice in a row while the other is waiting.
REQ-042 Assert reset in cycle 1 of a MEM_LAT=3 load -> busy=0 and all outputs 0 immediately; no d_done follows; a fresh fetch afterwards completes normally.
REQ-043 Sweep MEM_LAT=1 and MEM_LAT=4 with back-to-back loads -> done at N+2 and N+5 respectively; the one-IDLE-cycle gap holds; d_rdata is stable between the two accesses.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter and its bench.
package mem_arb_pkg;

   localparam int MEM_LAT_DEF = 2;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_RD,
      GRANT_WR,
      RESP
   } arbState_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port.
// Ties go to data unless data won the previous grant.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   arbState_e        state;
   arbState_e        nextState;
   logic [CNT_W-1:0] waitCnt;
   logic             grantData;
   logic             grantWe;
   logic             lastData;
   logic             pickData;
   logic             startGrant;
   logic [31:0]      addrQ;
   logic [31:0]      wdataQ;
   logic [31:0]      ifRdataQ;
   logic [31:0]      dRdataQ;

   assign pickData   = d_req & (~if_req | ~lastData);
   assign startGrant = (state == IDLE) & (d_req | if_req);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (pickData)    nextState = d_we ? GRANT_WR : GRANT_RD;
            else if (if_req) nextState = GRANT_RD;
         end
         GRANT_RD: if (waitCnt == '0) nextState = RESP;
         GRANT_WR: nextState = RESP;
         RESP:     nextState = IDLE;
         default:  nextState = IDLE;
      endcase
   end

   always_comb begin
      mem_wr  = 1'b0;
      if_done = 1'b0;
      d_done  = 1'b0;
      busy    = 1'b1;
      unique case (state)
         IDLE:     busy = 1'b0;
         GRANT_WR: mem_wr = grantWe;
         RESP: begin
            if_done = ~grantData;
            d_done  = grantData;
         end
         default: ;
      endcase
   end

   // Memory-side outputs come only from grant-time latches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         waitCnt   <= '0;
         grantData <= 1'b0;
         grantWe   <= 1'b0;
         lastData  <= 1'b0;
         addrQ     <= '0;
         wdataQ    <= '0;
         ifRdataQ  <= '0;
         dRdataQ   <= '0;
      end else if (startGrant) begin
         grantData <= pickData;
         grantWe   <= pickData & d_we;
         lastData  <= pickData;
         addrQ     <= pickData ? d_addr : if_addr;
         if (pickData) wdataQ <= d_wdata;
         if (!(pickData & d_we)) waitCnt <= CNT_W'(MEM_LAT - 1);
      end else if (state == GRANT_RD) begin
         if (waitCnt == '0) begin
            if (grantData) dRdataQ  <= mem_rdata;
            else           ifRdataQ <= mem_rdata;
         end else begin
            waitCnt <= waitCnt - CNT_W'(1);
         end
      end
   end

   assign mem_addr  = addrQ;
   assign mem_wdata = wdataQ;
   assign if_rdata  = ifRdataQ;
   assign d_rdata   = dRdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at MEM_LAT 1..4.
// Expected done events are queued at request time.
module tb_mem_arbiter;

   typedef struct {
      int          cyc;
      bit          isData;
      logic [31:0] ifRd;
      logic [31:0] dRd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifReq = 1'b0;
   logic [31:0] ifAddr = '0;
   logic        dReq = 1'b0;
   logic        dWe = 1'b0;
   logic [31:0] dAddr = '0;
   logic [31:0] dWdata = '0;

   logic        ifDoneA   [1:4];
   logic [31:0] ifRdataA  [1:4];
   logic        dDoneA    [1:4];
   logic [31:0] dRdataA   [1:4];
   logic [31:0] memAddrA  [1:4];
   logic        memWrA    [1:4];
   logic [31:0] memWdataA [1:4];
   logic [31:0] memRdataA [1:4];
   logic        busyA     [1:4];

   int   cyc = 0;
   int   sel = 2;
   int   nChecks = 0;
   int   nFails = 0;
   exp_t sb[$];
   logic [31:0] mIf = '0;
   logic [31:0] mD = '0;

   function automatic logic [31:0] memFn(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   for (genvar g = 1; g <= 4; g++) begin : gDut
      assign memRdataA[g] = memFn(memAddrA[g]);
      mem_arbiter #(.MEM_LAT(g)) u (
         .clock    (clk),
         .reset    (rst),
         .if_req   (ifReq),
         .if_addr  (ifAddr),
         .if_done  (ifDoneA[g]),
         .if_rdata (ifRdataA[g]),
         .d_req    (dReq),
         .d_we     (dWe),
         .d_addr   (dAddr),
         .d_wdata  (dWdata),
         .d_done   (dDoneA[g]),
         .d_rdata  (dRdataA[g]),
         .mem_addr (memAddrA[g]),
         .mem_wr   (memWrA[g]),
         .mem_wdata(memWdataA[g]),
         .mem_rdata(memRdataA[g]),
         .busy     (busyA[g])
      );
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s got=%h exp=%h cyc=%0d sel=%0d",
                  tag, got, exp, cyc, sel);
      end
   endtask

   task automatic goCycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pushExp(input bit isData, input bit isLoad,
                          input int c, input logic [31:0] data);
      exp_t e;
      if (isLoad) begin
         if (isData) mD = data;
         else        mIf = data;
      end
      e.cyc    = c;
      e.isData = isData;
      e.ifRd   = mIf;
      e.dRd    = mD;
      sb.push_back(e);
   endtask

   task automatic resetAll();
      check("sbDrained", 32'(sb.size()), 0);
      sb.delete();
      rst   = 1'b1;
      ifReq = 1'b0;
      dReq  = 1'b0;
      dWe   = 1'b0;
      goCycle(cyc + 2);
      rst = 1'b0;
      mIf = '0;
      mD  = '0;
   endtask

   task automatic checkZero(input string pfx);
      check({pfx, "Busy"},   32'(busyA[sel]), 0);
      check({pfx, "Addr"},   memAddrA[sel], 0);
      check({pfx, "Wdata"},  memWdataA[sel], 0);
      check({pfx, "Wr"},     32'(memWrA[sel]), 0);
      check({pfx, "IfDone"}, 32'(ifDoneA[sel]), 0);
      check({pfx, "DDone"},  32'(dDoneA[sel]), 0);
      check({pfx, "IfRd"},   ifRdataA[sel], 0);
      check({pfx, "DRd"},    dRdataA[sel], 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (ifDoneA[sel] || dDoneA[sel])) begin
         check("oneDone", 32'(ifDoneA[sel] & dDoneA[sel]), 0);
         if (sb.size() == 0) begin
            check("spuriousDone", 1, 0);
         end else begin
            e = sb.pop_front();
            check("donePort", 32'(dDoneA[sel]), 32'(e.isData));
            check("doneCyc", 32'(cyc), 32'(e.cyc));
            check("ifRdata", ifRdataA[sel], e.ifRd);
            check("dRdata", dRdataA[sel], e.dRd);
         end
      end
   end

   task automatic sweep(input int s);
      int base;
      sel = s;
      resetAll();
      base = cyc + 1;
      goCycle(base);
      dReq  = 1'b1;
      dWe   = 1'b0;
      dAddr = 32'h500;
      pushExp(1, 1, base + s + 1, memFn(32'h500));
      goCycle(base + s + 2);
      dAddr = 32'h504;
      pushExp(1, 1, base + 2 * s + 3, memFn(32'h504));
      check("gapIdle", 32'(busyA[sel]), 0);
      for (int k = base + s + 2; k <= base + 2 * s + 2; k++) begin
         goCycle(k);
         check("dRdHold", dRdataA[sel], memFn(32'h500));
      end
      goCycle(base + 2 * s + 4);
      dReq = 1'b0;
      goCycle(base + 2 * s + 8);
      check("sweepEmpty", 32'(sb.size()), 0);
   endtask

   initial begin
      int base;
      goCycle(3);
      checkZero("rst");
      rst = 1'b0;

      // both ports held: data, fetch, data, fetch
      base = cyc + 1;
      goCycle(base);
      ifReq  = 1'b1;
      ifAddr = 32'h100;
      dReq   = 1'b1;
      dWe    = 1'b0;
      dAddr  = 32'h80;
      pushExp(1, 1, base + 3,  memFn(32'h80));
      pushExp(0, 1, base + 7,  memFn(32'h100));
      pushExp(1, 1, base + 11, memFn(32'h84));
      pushExp(0, 1, base + 15, memFn(32'h104));
      goCycle(base + 4);
      dAddr = 32'h84;
      goCycle(base + 8);
      ifAddr = 32'h104;
      goCycle(base + 12);
      dReq = 1'b0;
      goCycle(base + 16);
      ifReq = 1'b0;
      goCycle(base + 20);
      check("arbEmpty", 32'(sb.size()), 0);

      // single fetch
      base = cyc + 1;
      goCycle(base);
      ifReq  = 1'b1;
      ifAddr = 32'h10;
      pushExp(0, 1, base + 3, 32'hDEADBEEF);
      goCycle(base + 1);
      check("fetchAddr1", memAddrA[sel], 32'h10);
      check("fetchBusy", 32'(busyA[sel]), 1);
      goCycle(base + 2);
      check("fetchAddr2", memAddrA[sel], 32'h10);
      goCycle(base + 4);
      ifReq = 1'b0;
      goCycle(base + 6);
      check("fetchHold", ifRdataA[sel], 32'hDEADBEEF);

      // single store
      base = cyc + 1;
      goCycle(base);
      dReq   = 1'b1;
      dWe    = 1'b1;
      dAddr  = 32'h40;
      dWdata = 32'h1234;
      pushExp(1, 0, base + 2, 0);
      for (int k = 0; k < 4; k++) begin
         goCycle(base + k);
         check("storeWr", 32'(memWrA[sel]), (k == 1) ? 1 : 0);
         if (k == 1) begin
            check("storeAddr", memAddrA[sel], 32'h40);
            check("storeData", memWdataA[sel], 32'h1234);
         end
         if (k == 3) begin
            dReq = 1'b0;
            dWe  = 1'b0;
         end
      end
      goCycle(base + 7);

      // reset in the middle of a MEM_LAT=3 load
      sel = 3;
      resetAll();
      base = cyc + 1;
      goCycle(base);
      ifReq  = 1'b1;
      ifAddr = 32'h300;
      pushExp(0, 1, base + 4, memFn(32'h300));
      goCycle(base + 5);
      ifReq = 1'b0;
      goCycle(base + 6);
      dReq  = 1'b1;
      dWe   = 1'b0;
      dAddr = 32'h200;
      goCycle(base + 7);
      check("midBusy", 32'(busyA[sel]), 1);
      rst  = 1'b1;
      dReq = 1'b0;
      #1;
      checkZero("mid");
      goCycle(base + 9);
      rst = 1'b0;
      mIf = '0;
      mD  = '0;
      goCycle(base + 14);
      check("noDoneAfterRst", 32'(sb.size()), 0);
      ifReq  = 1'b1;
      ifAddr = 32'h310;
      pushExp(0, 1, base + 18, memFn(32'h310));
      goCycle(base + 19);
      ifReq = 1'b0;
      goCycle(base + 22);

      sweep(1);
      sweep(4);

      check("sbFinal", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end

endmodule
